circuit_input_debounce: RTL and testbench
=========================================

CIRCUIT_INPUT_DEBOUNCE -- requirements
Module: circuit_input_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive cycles of a differing value required before an output changes; the legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port raw_in, input, 3 bits: asynchronous switch inputs; bit 2 maps to a, bit 1 to b, bit 0 to c.
REQ-005 The block SHALL have port a, output, 1 bit: the debounced raw_in[2], driving the combinational circuit's input a.
REQ-006 The block SHALL have port b, output, 1 bit: the debounced raw_in[1].
REQ-007 The block SHALL have port c, output, 1 bit: the debounced raw_in[0].
REQ-008 The block SHALL have port abc_changed, output, 1 bit: a one-cycle pulse when any of a, b or c changes.
REQ-009 The block SHALL have port change_count, output, 8 bits: the number of abc_changed pulses, wrapping modulo 256.

Function
REQ-010 Each raw_in bit SHALL pass through a two-flop synchronizer; s[i] denotes the second flop's output.
REQ-011 Each channel SHALL hold an 8-bit counter cnt[i] and a stable bit st[i]; outputs {a,b,c} SHALL equal {st[2],st[1],st[0]} directly, with no combinational path from raw_in.
REQ-012 On each clock edge, the per-channel update SHALL be:
- if s[i]==st[i]: cnt[i]<=0;
- else if cnt[i]==DEBOUNCE_CYCLES-1: st[i]<=s[i] and cnt[i]<=0;
- else: cnt[i]<=cnt[i]+1.
REQ-013 A raw_in bit change held steady SHALL appear on its output exactly DEBOUNCE_CYCLES+2 rising edges after it is set up before an edge (6 edges at default).
REQ-014 Any mismatch run shorter than DEBOUNCE_CYCLES cycles (glitch) SHALL clear cnt[i] when s[i] returns to st[i] and SHALL NOT change the output.
REQ-015 Channels SHALL be fully independent; each SHALL have its own counter, with no shared timing.
REQ-016 abc_changed SHALL be registered and asserted for exactly one cycle, on the same edge on which any st[i] changes, so it is coincident with the new {a,b,c} value.
REQ-017 Two or three channels updating on the same edge SHALL produce a single abc_changed pulse and a single change_count increment.
REQ-018 change_count SHALL increment by 1 on each edge where abc_changed is set, and SHALL wrap from 255 to 0 with no flag.
REQ-019 Continuous toggling of raw_in faster than the debounce window SHALL leave the outputs, abc_changed and change_count unchanged indefinitely.

Reset
REQ-020 While rst_n=0, all synchronizer flops, cnt[i], st[i], a, b, c, abc_changed and change_count SHALL be 0, asynchronously, regardless of clk.
REQ-021 Reset asserted mid-count SHALL discard the partial count; after release, debounce SHALL restart from cnt=0 against st=0.
REQ-022 After reset deassertion, rst_n SHALL be treated as synchronously released by the system.
REQ-023 If raw_in is nonzero at reset release, the outputs SHALL follow it DEBOUNCE_CYCLES+2 edges later, with one abc_changed pulse.

Verification
REQ-024 The bench SHALL cover reset with raw_in=3'b000, then set raw_in=3'b101 and hold -> {a,b,c}=101 and abc_changed=1 on edge 6 only, with change_count=1.
REQ-025 The bench SHALL cover, from abc=000, a raw_in[1] high glitch of 3 cycles -> b stays 0, abc_changed stays 0, change_count stays 0.
REQ-026 The bench SHALL cover stepping raw_in through 0..7, holding each value 10 cycles -> a,b,c track each value 6 cycles late, change_count=7, and every output pattern is applied to the downstream circuit.
REQ-027 The bench SHALL cover setting raw_in=3'b111 from 000 in a single cycle -> all three outputs change on the same edge, with one pulse and a count increment of 1.
REQ-028 The bench SHALL cover forcing 256 output changes -> change_count returns to 0.
REQ-029 The bench SHALL cover asserting rst_n=0 mid-debounce (cnt=2) between clock edges -> outputs go to 0 immediately; after release with raw_in=3'b010, b=1 arrives 6 edges later.

Source files
------------

// File: rtl/circuit_input_debounce.sv
// ---------------------------------------------------------------------------
// circuit_input_debounce
//
// Debounces three asynchronous switch inputs for a downstream combinational
// circuit. Each switch is synchronised with two flops and must then show a
// value different from its stable state for DEBOUNCE_CYCLES consecutive
// cycles before the stable state (and its output) follows. A single-cycle
// pulse marks every edge on which any output changes, and a wrapping 8-bit
// counter tallies those pulses.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to change an output
//                    (legal range 2..255)
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   raw_in[2:0]   raw switch inputs; bit 2 -> a, bit 1 -> b, bit 0 -> c
//   a, b, c       debounced switch values, straight from registers
//   abc_changed   one-cycle pulse coincident with any change of a, b or c
//   change_count  number of abc_changed pulses, modulo 256
// ---------------------------------------------------------------------------
module circuit_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] raw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       abc_changed,
    output logic [7:0] change_count
);

    // Counter value at which the mismatch run is long enough to accept the
    // new level; the accept happens on the same edge that sees this value.
    localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

    logic [2:0] sync_meta;
    logic [2:0] sync_out;
    logic [2:0] st;
    logic [2:0] upd;
    logic [7:0] cnt      [3];
    logic [7:0] cnt_next [3];

    // Two-flop synchronizer per channel. The first stage may go metastable;
    // only the second stage is ever looked at by the debounce logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 3'b000;
            sync_out  <= 3'b000;
        end else begin
            sync_meta <= raw_in;
            sync_out  <= sync_meta;
        end
    end

    // Per-channel debounce decision. A synchronised value equal to the
    // stable state clears the run counter, so any glitch shorter than the
    // window is forgotten. upd[i] flags the edge on which st[i] flips.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            upd[i]      = 1'b0;
            cnt_next[i] = cnt[i];
            if (sync_out[i] == st[i]) begin
                cnt_next[i] = 8'd0;
            end else if (cnt[i] == LAST_COUNT) begin
                upd[i]      = 1'b1;
                cnt_next[i] = 8'd0;
            end else begin
                cnt_next[i] = cnt[i] + 8'd1;
            end
        end
    end

    // Run counters and stable bits. A flip is a toggle because the stable
    // bit only ever moves toward the (differing) synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= 8'd0;
            end
            st <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_next[i];
            end
            st <= st ^ upd;
        end
    end

    // Change pulse and tally. Both are registered on the same edge as the
    // stable bits, so the pulse lines up with the new output value, and
    // simultaneous flips on several channels count as one change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abc_changed  <= 1'b0;
            change_count <= 8'd0;
        end else begin
            abc_changed <= |upd;
            if (|upd) begin
                change_count <= change_count + 8'd1;
            end
        end
    end

    assign a = st[2];
    assign b = st[1];
    assign c = st[0];

endmodule

// File: tb/tb_circuit_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_circuit_input_debounce
//
// Directed bench for circuit_input_debounce at the default window of 4.
// Inputs change one time unit after a rising edge; outputs are sampled at
// that same point, i.e. after the edge has settled. With a window of 4 a
// steady change lands on the 6th edge after it is applied.
// ---------------------------------------------------------------------------
module tb_circuit_input_debounce;

    logic       clk;
    logic       rst_n;
    logic [2:0] raw_in;
    logic       a;
    logic       b;
    logic       c;
    logic       abc_changed;
    logic [7:0] change_count;

    int assertCount;
    int failCount;

    logic [7:0] seenPatterns;
    logic [2:0] prevValue;

    circuit_input_debounce #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .a           (a),
        .b           (b),
        .c           (c),
        .abc_changed (abc_changed),
        .change_count(change_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] value);
        raw_in = value;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold reset across two edges with inputs low, release just after an edge.
    task automatic pulseReset();
        rst_n  = 1'b0;
        raw_in = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        seenPatterns = 8'h00;
        rst_n        = 1'b0;
        raw_in       = 3'b000;

        // Reset state
        tick();
        tick();
        checkOutput("reset_abc", {29'd0, a, b, c}, 32'd0);
        checkOutput("reset_pulse", {31'd0, abc_changed}, 32'd0);
        checkOutput("reset_count", {24'd0, change_count}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Three-cycle high glitch on raw_in[1] must be ignored
        $display("[TB] glitch on b");
        applyStimulus(3'b010);
        tick();
        tick();
        tick();
        applyStimulus(3'b000);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("glitch_b", {31'd0, b}, 32'd0);
            checkOutput("glitch_pulse", {31'd0, abc_changed}, 32'd0);
        end
        checkOutput("glitch_count", {24'd0, change_count}, 32'd0);

        // Continuous toggling faster than the window
        $display("[TB] fast toggling on a");
        for (int k = 0; k < 24; k++) begin
            applyStimulus(((k / 2) % 2) == 0 ? 3'b100 : 3'b000);
            tick();
            checkOutput("toggle_pulse", {31'd0, abc_changed}, 32'd0);
        end
        applyStimulus(3'b000);
        for (int k = 0; k < 6; k++) tick();
        checkOutput("toggle_abc", {29'd0, a, b, c}, 32'd0);
        checkOutput("toggle_count", {24'd0, change_count}, 32'd0);

        // Step to 101 and hold: change on edge 6 only
        $display("[TB] step to 101");
        applyStimulus(3'b101);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checkOutput("s101_abc", {29'd0, a, b, c}, (e >= 6) ? 32'd5 : 32'd0);
            checkOutput("s101_pulse", {31'd0, abc_changed}, (e == 6) ? 32'd1 : 32'd0);
            checkOutput("s101_count", {24'd0, change_count}, (e >= 6) ? 32'd1 : 32'd0);
        end

        // Walk raw_in through 0..7 holding each value 10 cycles
        $display("[TB] walk 0..7");
        pulseReset();
        checkOutput("walk_reset_abc", {29'd0, a, b, c}, 32'd0);
        prevValue = 3'b000;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(3'(v));
            for (int k = 1; k <= 10; k++) begin
                tick();
                seenPatterns[{a, b, c}] = 1'b1;
                checkOutput("walk_abc", {29'd0, a, b, c},
                            (k >= 6) ? 32'(v) : {29'd0, prevValue});
                checkOutput("walk_pulse", {31'd0, abc_changed},
                            (k == 6 && 3'(v) != prevValue) ? 32'd1 : 32'd0);
            end
            prevValue = 3'(v);
        end
        checkOutput("walk_count", {24'd0, change_count}, 32'd7);
        checkOutput("walk_patterns", {24'd0, seenPatterns}, 32'hFF);

        // All three channels flipping on the same edge
        $display("[TB] 000 to 111");
        applyStimulus(3'b000);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("pre111_abc", {29'd0, a, b, c}, 32'd0);
        checkOutput("pre111_count", {24'd0, change_count}, 32'd8);
        applyStimulus(3'b111);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checkOutput("s111_abc", {29'd0, a, b, c}, (e >= 6) ? 32'd7 : 32'd0);
            checkOutput("s111_pulse", {31'd0, abc_changed}, (e == 6) ? 32'd1 : 32'd0);
            checkOutput("s111_count", {24'd0, change_count}, (e >= 6) ? 32'd9 : 32'd8);
        end

        // 256 output changes wrap the counter back to 0
        $display("[TB] counter wrap");
        pulseReset();
        for (int n = 1; n <= 256; n++) begin
            applyStimulus({2'b00, (n % 2) == 1});
            for (int k = 0; k < 8; k++) tick();
            if (n == 255) begin
                checkOutput("wrap_255", {24'd0, change_count}, 32'd255);
                checkOutput("wrap_c_odd", {31'd0, c}, 32'd1);
            end
        end
        checkOutput("wrap_0", {24'd0, change_count}, 32'd0);
        checkOutput("wrap_c_even", {31'd0, c}, 32'd0);

        // Reset in the middle of a debounce run
        $display("[TB] reset mid-debounce");
        applyStimulus(3'b111);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("pre_rst_abc", {29'd0, a, b, c}, 32'd7);
        applyStimulus(3'b010);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("pre_rst_hold", {29'd0, a, b, c}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_abc", {29'd0, a, b, c}, 32'd0);
        checkOutput("async_rst_pulse", {31'd0, abc_changed}, 32'd0);
        checkOutput("async_rst_count", {24'd0, change_count}, 32'd0);
        tick();
        checkOutput("rst_held_abc", {29'd0, a, b, c}, 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checkOutput("post_rst_abc", {29'd0, a, b, c}, (e >= 6) ? 32'd2 : 32'd0);
            checkOutput("post_rst_pulse", {31'd0, abc_changed}, (e == 6) ? 32'd1 : 32'd0);
        end
        checkOutput("post_rst_count", {24'd0, change_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
